// File: rtl/axis_rx_buffer.sv
// AXI4-Stream receive buffer: DEPTH-entry FIFO with a local pop port and a sticky master-protocol checker.
// Optional per-beat TLAST storage is enabled by defining AXIS_RX_TLAST_EN.
module axis_rx_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  input  logic                         TVALID,
  input  logic [DATA_W-1:0]            TDATA,
`ifdef AXIS_RX_TLAST_EN
  input  logic                         TLAST,
  output logic                         rd_last,
`endif
  output logic                         TREADY,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         proto_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH+1);
`ifdef AXIS_RX_TLAST_EN
  localparam int unsigned EW = DATA_W + 1;
`else
  localparam int unsigned EW = DATA_W;
`endif

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          init_done_q;
  logic          stall_q, stall_d;
  logic [EW-1:0] stall_beat_q, stall_beat_d;
  logic          proto_err_q, proto_err_d;
  logic [EW-1:0] beat_in, head;
  logic          push, pop;

`ifdef AXIS_RX_TLAST_EN
  assign beat_in = {TLAST, TDATA};
  assign rd_last = head[DATA_W];
`else
  assign beat_in = TDATA;
`endif

  // Ready comes only from registered state, so it never loops back through TVALID.
  assign TREADY    = init_done_q && (level_q != LW'(DEPTH));
  assign rd_valid  = (level_q != '0);
  assign head      = mem_q[rd_ptr_q];
  assign rd_data   = head[DATA_W-1:0];
  assign level     = level_q;
  assign proto_err = proto_err_q;

  assign push = TVALID && TREADY;
  assign pop  = rd_valid && rd_ready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    stall_d      = TVALID && !TREADY;
    stall_beat_d = beat_in;
    proto_err_d  = proto_err_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    // A stalled beat must be held unchanged (valid and payload) until accepted.
    if (stall_q && (!TVALID || (beat_in != stall_beat_q))) proto_err_d = 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      init_done_q  <= 1'b0;
      stall_q      <= 1'b0;
      stall_beat_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      init_done_q  <= 1'b1;
      stall_q      <= stall_d;
      stall_beat_q <= stall_beat_d;
      proto_err_q  <= proto_err_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= beat_in;
  end

endmodule

// File: doc/axis_rx_buffer.md
AXIS_RX_BUFFER -- requirements
Module: axis_rx_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, TDATA/rd_data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-003 SHALL have port ACLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port ARESETn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port TVALID  input  1  AXI4-Stream master valid.
REQ-006 SHALL have port TDATA  input  DATA_W  AXI4-Stream data.
REQ-007 SHALL have port TREADY  output  1  AXI4-Stream slave ready.
REQ-008 SHALL have port rd_valid  output  1  head entry available locally.
REQ-009 SHALL have port rd_data  output  DATA_W  head entry data.
REQ-010 SHALL have port rd_ready  input  1  local consumer pops head.
REQ-011 SHALL have port level  output  $clog2(DEPTH+1)  occupied entries.
REQ-012 SHALL have port proto_err  output  1  sticky AXI4-Stream master rule violation.

Function
REQ-013 SHALL implement an AXI4-Stream receiver: a transfer occurs at a rising ACLK edge where TVALID=1 and TREADY=1.
REQ-014 SHALL drive TREADY = init_done AND (level != DEPTH); TREADY depends on no input combinationally.
REQ-015 SHALL hold init_done at 0 during reset and set it at the first rising ACLK edge with ARESETn high; TREADY is therefore 0 for the first cycle after reset release.
REQ-016 SHALL write TDATA to the entry at the write pointer on each transfer; the pointer increments modulo DEPTH.
REQ-017 SHALL drive rd_valid = (level != 0) and rd_data = entry at the read pointer, both from registers/storage only.
REQ-018 SHALL pop on rd_valid AND rd_ready; the read pointer increments modulo DEPTH; rd_ready while empty is ignored.
REQ-019 SHALL present a beat transferred at edge k on rd_data with rd_valid=1 from edge k onward (one-cycle latency, no bypass).
REQ-020 SHALL update level by +1 (push only), -1 (pop only), 0 (both or neither); simultaneous push and pop at any level between 1 and DEPTH-1 keeps level unchanged and is lossless.
REQ-021 SHALL never overflow: when full, TREADY=0, so no push occurs; a same-cycle pop raises TREADY on the next cycle, not the current one.
REQ-022 SHALL preserve beat order exactly (FIFO).
REQ-023 SHALL register a stall flag when TVALID=1 and TREADY=0 at an edge, and set proto_err at the next edge if TVALID=0 or TDATA differs from the registered stalled value.
REQ-024 SHALL keep proto_err at 1 once set until reset; a violation does not alter FIFO behaviour.

Reset
REQ-025 SHALL, on ARESETn=0, immediately clear TREADY, rd_valid, level, proto_err, the stall flag, init_done and both pointers, independent of ACLK.
REQ-026 SHALL discard all buffered entries on reset mid-operation; storage contents need not be cleared; rd_data is don't-care while rd_valid=0.
REQ-027 SHALL ignore TVALID and rd_ready while ARESETn=0.

Configuration
REQ-028 SHALL support macro AXIS_RX_TLAST_EN: when defined, add input TLAST (1) and output rd_last (1); store TLAST per entry alongside TDATA; present rd_last with rd_data; a TLAST change during a stall sets proto_err.
REQ-029 SHALL, without AXIS_RX_TLAST_EN, omit TLAST and rd_last, with all other behaviour identical.

Verification
REQ-030 SHALL cover reset release: ARESETn 0->1, TVALID=1 held -> TREADY=0 for the first cycle, 1 for the second; first beat accepted at the second edge.
REQ-031 SHALL cover fill and drain: DEPTH=4, push 0xA0..0xA3 with rd_ready=0 -> level=4, TREADY=0; then rd_ready=1 -> rd_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, level back to 0.
REQ-032 SHALL cover simultaneous push and pop at level=2 -> level stays 2; order preserved across pointer wrap (more than 8 beats streamed).
REQ-033 SHALL cover a protocol violation: full buffer, TVALID=1 with TDATA=0x55, next cycle TDATA=0x56 -> proto_err=1 and held until ARESETn=0.
REQ-034 SHALL cover reset mid-stream: level=3, ARESETn pulsed low between edges -> level=0, rd_valid=0, TREADY=0 with no clock edge.
REQ-035 SHALL cover AXIS_RX_TLAST_EN: beats (0x1,TLAST=0),(0x2,TLAST=1) -> rd_last 0 then 1 with matching rd_data.
